sqrt_result_packer: RTL and testbench

//  Output end of the square-root datapath: consumes the unpacked result stream of the iterative

---
 rtl/sqrt_result_packer.sv | 123 ++++++++++++
 tb/tb_sqrt_result_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_result_packer.sv
// rtl/sqrt_result_packer.sv - binary16 encoder, final-capture FSM and 2-deep output FIFO for sqrt results
// Optional feature macro: SQRT_PARTIALS_EN (push partial step words with out_last=0)
module sqrt_result_packer #(
  parameter int          DROP_CNT_W = 8,
  parameter logic [15:0] NAN_CODE   = 16'hFE00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  it_valid,
  input  logic                  result,
  input  logic                  sign_in,
  input  logic [6:0]            exp_in,
  input  logic [10:0]           mant_in,
  input  logic                  is_nan_in,
  input  logic                  is_pinf_in,
  input  logic                  is_ninf_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic                  out_last,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;

  localparam logic [6:0] EXP_MIN = 7'h71;  // -15 in 7-bit two's complement
  localparam logic [6:0] EXP_MAX = 7'd16;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [15:0]           data_q [2];
  logic                  last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  logic [15:0] enc_word;
  logic        pop;
  logic        final_req;
  logic        final_push;
  logic        partial_push;
  logic        push;

  // Encode the live unpacked result into a binary16 word; flags take priority over exponent cases
  always_comb begin
    enc_word = {sign_in, exp_in[4:0] + 5'd15, mant_in[9:0]};
    if (is_nan_in || is_ninf_in) begin
      enc_word = NAN_CODE;
    end else if (is_pinf_in) begin
      enc_word = 16'h7C00;
    end else if (exp_in == EXP_MIN) begin
      if (mant_in == 11'd0) enc_word = {sign_in, 15'h0000};
      else                  enc_word = {sign_in, 5'd0, mant_in[10:1]};
    end else if (exp_in == EXP_MAX) begin
      enc_word = {sign_in, 5'h1F, 10'h000};
    end
  end

  // Push/pop arbitration: a final may use the slot freed by a same-cycle pop,
  // partials only enter an empty FIFO so they can never starve a final
  always_comb begin
    pop        = (count_q != 2'd0) && out_ready;
    final_req  = enable && (((state_q == IDLE) && it_valid && result) || (state_q == PENDING));
    final_push = final_req && ((count_q != 2'd2) || pop);
`ifdef SQRT_PARTIALS_EN
    partial_push = enable && (state_q == IDLE) && it_valid && !result && (count_q == 2'd0);
`else
    partial_push = 1'b0;
`endif
    push = final_push || partial_push;
  end

  // Final-capture FSM: one word per operation, lost finals counted when aborted while pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drop_cnt_q <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      if ((state_q == PENDING) && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_ONE;
    end else begin
      case (state_q)
        IDLE:    if (it_valid && result) state_q <= final_push ? DONE : PENDING;
        PENDING: if (final_push) state_q <= DONE;
        DONE:    if (!result) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry circular FIFO holding {data,last}; enable never flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= 16'h0000;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= enc_word;
        last_q[wr_ptr_q] <= final_push;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_last  = last_q[rd_ptr_q];
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sqrt_result_packer.sv
// tb/tb_sqrt_result_packer.sv - directed table-driven bench for sqrt_result_packer
module tb_sqrt_result_packer;

  logic        clk, rst_n, enable, it_valid, result, sign_in;
  logic [6:0]  exp_in;
  logic [10:0] mant_in;
  logic        is_nan_in, is_pinf_in, is_ninf_in;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [16:0] popq[$];

  typedef struct {
    logic        sign;
    logic [6:0]  e;
    logic [10:0] m;
    logic        nan, pinf, ninf;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[13];

  sqrt_result_packer #(.DROP_CNT_W(8), .NAN_CODE(16'hFE00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .it_valid(it_valid), .result(result),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .is_nan_in(is_nan_in),
    .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every handshake that will complete at the coming rising edge
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) popq.push_back({out_last, out_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_word(input logic s, input logic [6:0] e, input logic [10:0] m);
    sign_in = s; exp_in = e; mant_in = m;
    is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; it_valid = 1'b0; result = 1'b0;
  endtask

  task automatic final_op(input logic [6:0] e);
    set_word(1'b0, e, 11'h400);
    enable = 1'b1; it_valid = 1'b1; result = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    int n_part, n_fin;
    vecs[0]  = '{1'b0, 7'd0,  11'h400, 1'b0, 1'b0, 1'b0, 16'h3C00};
    vecs[1]  = '{1'b1, 7'h71, 11'h000, 1'b0, 1'b0, 1'b0, 16'h8000};
    vecs[2]  = '{1'b0, 7'd0,  11'h400, 1'b1, 1'b0, 1'b0, 16'hFE00};
    vecs[3]  = '{1'b0, 7'd0,  11'h400, 1'b0, 1'b0, 1'b1, 16'hFE00};
    vecs[4]  = '{1'b0, 7'd0,  11'h400, 1'b0, 1'b1, 1'b0, 16'h7C00};
    vecs[5]  = '{1'b1, 7'd3,  11'h400, 1'b1, 1'b1, 1'b0, 16'hFE00};
    vecs[6]  = '{1'b1, 7'h71, 11'h000, 1'b0, 1'b1, 1'b0, 16'h7C00};
    vecs[7]  = '{1'b0, 7'h71, 11'h3FF, 1'b0, 1'b0, 1'b0, 16'h01FF};
    vecs[8]  = '{1'b1, 7'h71, 11'h001, 1'b0, 1'b0, 1'b0, 16'h8000};
    vecs[9]  = '{1'b1, 7'd16, 11'h5A5, 1'b0, 1'b0, 1'b0, 16'hFC00};
    vecs[10] = '{1'b0, 7'd15, 11'h7FF, 1'b0, 1'b0, 1'b0, 16'h7BFF};
    vecs[11] = '{1'b1, 7'h72, 11'h400, 1'b0, 1'b0, 1'b0, 16'h8400};
    vecs[12] = '{1'b0, 7'h7F, 11'h600, 1'b0, 1'b0, 1'b0, 16'h3A00};

    rst_n = 1'b0; out_ready = 1'b0;
    idle_inputs();
    set_word(1'b0, 7'd0, 11'h400);
    tick(2);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_last", out_last, 0);
    check("reset drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Encoding vectors, one final per operation, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sign_in = vecs[i].sign; exp_in = vecs[i].e; mant_in = vecs[i].m;
      is_nan_in = vecs[i].nan; is_pinf_in = vecs[i].pinf; is_ninf_in = vecs[i].ninf;
      enable = 1'b1; it_valid = 1'b1; result = 1'b1;
      tick();
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].word);
      check($sformatf("vec%0d out_last", i), out_last, 1);
      idle_inputs();
      tick();
      check($sformatf("vec%0d drained", i), out_valid, 0);
    end

    // Result held 20 cycles gives one word; a new operation gives a second
    tick();
    popq.delete();
    set_word(1'b0, 7'd0, 11'h400);
    enable = 1'b1; it_valid = 1'b1; result = 1'b1;
    tick(20);
    idle_inputs();
    tick(2);
    check("hold20 word count", popq.size(), 1);
    if (popq.size() >= 1) check("hold20 word", popq[0], 17'h13C00);
    final_op(7'd1);
    tick();
    check("second op count", popq.size(), 2);
    if (popq.size() >= 2) check("second op word", popq[1], 17'h14000);

    // Backpressure: A,B queued, C pending, one pop admits C in the same cycle
    popq.delete();
    out_ready = 1'b0;
    final_op(7'd0);
    final_op(7'd1);
    set_word(1'b0, 7'd2, 11'h400);
    enable = 1'b1; it_valid = 1'b1; result = 1'b1;
    tick(3);
    check("full head A", out_data, 16'h3C00);
    check("full valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(2);
    check("after pop head B", out_data, 16'h4000);
    check("no drop on capture", drop_cnt, 0);
    idle_inputs();
    out_ready = 1'b1;
    tick(4);
    check("order count", popq.size(), 3);
    if (popq.size() == 3) begin
      check("order A", popq[0], 17'h13C00);
      check("order B", popq[1], 17'h14000);
      check("order C", popq[2], 17'h14400);
    end
    check("order drained", out_valid, 0);

    // Abort while pending loses C and counts it; counter saturates
    popq.delete();
    out_ready = 1'b0;
    final_op(7'd0);
    final_op(7'd1);
    set_word(1'b0, 7'd2, 11'h400);
    enable = 1'b1; it_valid = 1'b1; result = 1'b1;
    tick(2);
    idle_inputs();
    tick();
    check("drop_cnt one", drop_cnt, 1);
    check("fifo kept on abort", out_data, 16'h3C00);
    for (int k = 0; k < 300; k++) begin
      enable = 1'b1; it_valid = 1'b1; result = 1'b1;
      tick();
      idle_inputs();
      tick();
    end
    check("drop_cnt saturated", drop_cnt, 255);
    check("fifo still valid", out_valid, 1);

    // Async reset mid-PENDING with a full FIFO
    enable = 1'b1; it_valid = 1'b1; result = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst drop_cnt", drop_cnt, 0);
    check("async rst out_data", out_data, 0);
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    popq.delete();
    out_ready = 1'b1;
    final_op(7'd0);
    tick();
    check("post reset count", popq.size(), 1);
    if (popq.size() >= 1) check("post reset word", popq[0], 17'h13C00);

    // 11-step operation: 10 partial steps then the held final
    popq.delete();
    out_ready = 1'b1;
    enable = 1'b1; it_valid = 1'b1; result = 1'b0;
    for (int s = 0; s < 10; s++) begin
      set_word(1'b0, 7'd0, 11'h400 + 11'(s));
      tick();
    end
    result = 1'b1;
    tick(3);
    idle_inputs();
    tick(3);
    n_part = 0; n_fin = 0;
    foreach (popq[j]) begin
      if (popq[j][16]) n_fin++;
      else n_part++;
    end
`ifdef SQRT_PARTIALS_EN
    check("partial words", n_part, 5);
`else
    check("partial words", n_part, 0);
`endif
    check("final words", n_fin, 1);
    if (popq.size() >= 1) check("last word is final", popq[popq.size()-1], 17'h13C09);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
